// File: rtl/tsc_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM state
// encoding, default word/address widths and the latency counter width.
package tsc_mem_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word storage: synchronous write, combinational read through
// the same address. Contents are deliberately not reset.
module mem_array_sp
    import tsc_mem_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Commit a write on the clock edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder for the MEM pipeline stage. A request is
// latched in IDLE, held for LATENCY cycles and completed with a one-cycle ack.
// Optional feature macro: MEM_RESP_RANGE_CHK_EN adds the mem_err port and
// suppresses accesses whose address is at or beyond DEPTH.
module mem_responder
    import tsc_mem_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_RESP_RANGE_CHK_EN
    ,
    output logic              mem_err
`endif
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic [ADDR_W-1:0]   portAddr;
    logic [WORD_W-1:0]   portWdata;
    logic                portWrite;
    logic                enterAck;
    logic                arrayWe;
    logic [WORD_W-1:0]   arrayRdata;
    logic                readOk;

    // State and request-latch registers; reset is synchronous and active high.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, single ACK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    write_d = mem_write;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array port mux: live inputs when a LATENCY=1 request enters ACK from
    // IDLE, latched copy otherwise; the write lands on the edge entering ACK.
    always_comb begin
        portAddr  = addr_q;
        portWdata = wdata_q;
        portWrite = write_q;
        if (state_q == IDLE) begin
            portAddr  = mem_addr;
            portWdata = mem_wdata;
            portWrite = mem_write;
        end
    end

    assign enterAck = (state_d == ACK) && (state_q != ACK);

`ifdef MEM_RESP_RANGE_CHK_EN
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic outOfRange;

    assign outOfRange = {1'b0, portAddr} >= DEPTH_V;
    assign arrayWe    = enterAck && portWrite && !reset_n && !outOfRange;
    assign readOk     = (state_q == ACK) && !write_q && !outOfRange;
    assign mem_err    = (state_q == ACK) && outOfRange;
`else
    logic unusedAddrBits;

    assign unusedAddrBits = ^portAddr;
    assign arrayWe        = enterAck && portWrite && !reset_n;
    assign readOk         = (state_q == ACK) && !write_q;
`endif

    mem_array_sp #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arrayWe),
        .addr_i  (portAddr[IDX_W-1:0]),
        .wdata_i (portWdata),
        .rdata_o (arrayRdata)
    );

    assign mem_ack   = (state_q == ACK);
    assign busy      = (state_q != IDLE);
    assign mem_rdata = readOk ? arrayRdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2 and one at
// LATENCY=1, with hand-computed expectations. Honours MEM_RESP_RANGE_CHK_EN.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        rd0, wr0, ack0, busy0;
    logic [15:0] addr0, wdata0, rdata0;
    logic        rd1, wr1, ack1, busy1;
    logic [15:0] addr1, wdata1, rdata1;
`ifdef MEM_RESP_RANGE_CHK_EN
    logic        err0, err1;
`endif

    int total = 0;
    int bad   = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    mem_responder #(
        .WORD_W  (16),
        .ADDR_W  (16),
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset),
        .mem_read  (rd0),
        .mem_write (wr0),
        .mem_addr  (addr0),
        .mem_wdata (wdata0),
        .mem_ack   (ack0),
        .mem_rdata (rdata0),
        .busy      (busy0)
`ifdef MEM_RESP_RANGE_CHK_EN
        ,
        .mem_err   (err0)
`endif
    );

    mem_responder #(
        .WORD_W  (16),
        .ADDR_W  (16),
        .DEPTH   (256),
        .LATENCY (1)
    ) dut1 (
        .clk       (clk),
        .reset_n   (reset),
        .mem_read  (rd1),
        .mem_write (wr1),
        .mem_addr  (addr1),
        .mem_wdata (wdata1),
        .mem_ack   (ack1),
        .mem_rdata (rdata1),
        .busy      (busy1)
`ifdef MEM_RESP_RANGE_CHK_EN
        ,
        .mem_err   (err1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete access: raise the request, optionally move the address
    // after acceptance, wait (bounded) for the ack, drop the request in the
    // ack cycle and confirm the responder is idle afterwards.
    task automatic applyStimulus(input string tag, input bit sel,
                                 input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] waitAddr,
                                 input logic [15:0] wdata, input int expLat,
                                 input logic [15:0] expRdata, input logic expErr);
        int          ackAt;
        logic        busyFirst;
        logic [15:0] rdataAt;
        logic        errAt;
        ackAt     = 0;
        busyFirst = 1'b0;
        rdataAt   = '0;
        errAt     = 1'b0;
        @(negedge clk);
        if (sel) begin
            rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = wdata;
        end else begin
            rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = wdata;
        end
        for (int k = 1; k <= 20 && ackAt == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                busyFirst = sel ? busy1 : busy0;
                if (sel) addr1 = waitAddr;
                else     addr0 = waitAddr;
            end
            if ((sel ? ack1 : ack0) == 1'b1) begin
                ackAt   = k;
                rdataAt = sel ? rdata1 : rdata0;
`ifdef MEM_RESP_RANGE_CHK_EN
                errAt   = sel ? err1 : err0;
`endif
            end
        end
        if (sel) begin
            rd1 = 1'b0; wr1 = 1'b0;
        end else begin
            rd0 = 1'b0; wr0 = 1'b0;
        end
        checkOutput({tag, ".lat"}, ackAt, expLat);
        checkOutput({tag, ".busy"}, {31'd0, busyFirst}, 32'd1);
        if (rd && !wr) begin
            checkOutput({tag, ".rdata"}, {16'd0, rdataAt}, {16'd0, expRdata});
        end
`ifdef MEM_RESP_RANGE_CHK_EN
        checkOutput({tag, ".err"}, {31'd0, errAt}, {31'd0, expErr});
`else
        if (expErr) $display("[TB] note: %s expects mem_err but the port is absent", tag);
`endif
        @(posedge clk);
        #1;
        checkOutput({tag, ".idle"},
                    sel ? {30'd0, ack1, busy1} : {30'd0, ack0, busy0}, 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        int          firstAck;
        int          secondAck;
        logic [1:0]  gapState;
        logic [15:0] secondRdata;

        reset = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.ack", {31'd0, ack0}, 32'd0);
        checkOutput("reset.busy", {31'd0, busy0}, 32'd0);
        checkOutput("reset.rdata", {16'd0, rdata0}, 32'd0);
`ifdef MEM_RESP_RANGE_CHK_EN
        checkOutput("reset.err", {31'd0, err0}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Basic write then read-back at LATENCY=2.
        applyStimulus("wr5", 1'b0, 1'b0, 1'b1, 16'd5, 16'd5, 16'h1234, 2, 16'h0000, 1'b0);
        applyStimulus("rd5", 1'b0, 1'b1, 1'b0, 16'd5, 16'd5, 16'h0000, 2, 16'h1234, 1'b0);

        // Read held through ACK: second ack LATENCY+1 cycles after the first.
        firstAck    = 0;
        secondAck   = 0;
        gapState    = 2'b11;
        secondRdata = '0;
        @(negedge clk);
        rd0 = 1'b1; addr0 = 16'd5;
        for (int k = 1; k <= 30 && secondAck == 0; k++) begin
            @(posedge clk);
            #1;
            if (firstAck != 0 && k == firstAck + 1) gapState = {ack0, busy0};
            if (ack0) begin
                if (firstAck == 0) begin
                    firstAck = k;
                end else begin
                    secondAck   = k;
                    secondRdata = rdata0;
                end
            end
        end
        rd0 = 1'b0;
        checkOutput("held.first", firstAck, 2);
        checkOutput("held.spacing", secondAck - firstAck, 3);
        checkOutput("held.gap", {30'd0, gapState}, 32'd0);
        checkOutput("held.rdata", {16'd0, secondRdata}, 32'h1234);
        @(posedge clk);
        #1;

        // Reset in WAIT abandons the write.
        applyStimulus("pre3", 1'b0, 1'b0, 1'b1, 16'd3, 16'd3, 16'h0000, 2, 16'h0000, 1'b0);
        @(negedge clk);
        wr0 = 1'b1; addr0 = 16'd3; wdata0 = 16'hAAAA;
        @(posedge clk);
        #1;
        checkOutput("rstwait.busy", {31'd0, busy0}, 32'd1);
        reset = 1'b1;
        wr0   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstwait.idle", {30'd0, ack0, busy0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstwait.noack", {31'd0, ack0}, 32'd0);
        applyStimulus("rd3", 1'b0, 1'b1, 1'b0, 16'd3, 16'd3, 16'h0000, 2, 16'h0000, 1'b0);

        // Address changed during WAIT: the latched address is used.
        applyStimulus("pre11", 1'b0, 1'b0, 1'b1, 16'd11, 16'd11, 16'h1111, 2, 16'h0000, 1'b0);
        applyStimulus("wr10", 1'b0, 1'b0, 1'b1, 16'd10, 16'd11, 16'h7777, 2, 16'h0000, 1'b0);
        applyStimulus("rd10", 1'b0, 1'b1, 1'b0, 16'd10, 16'd10, 16'h0000, 2, 16'h7777, 1'b0);
        applyStimulus("rd11", 1'b0, 1'b1, 1'b0, 16'd11, 16'd11, 16'h0000, 2, 16'h1111, 1'b0);

        // LATENCY=1 with read and write both high behaves as a write.
        applyStimulus("l1rw9", 1'b1, 1'b1, 1'b1, 16'd9, 16'd9, 16'hBEEF, 1, 16'h0000, 1'b0);
        applyStimulus("l1rd9", 1'b1, 1'b1, 1'b0, 16'd9, 16'd9, 16'h0000, 1, 16'hBEEF, 1'b0);

        // Address beyond DEPTH: suppressed with range check, wraps without.
`ifdef MEM_RESP_RANGE_CHK_EN
        applyStimulus("wr105", 1'b0, 1'b0, 1'b1, 16'h0105, 16'h0105, 16'h5555, 2, 16'h0000, 1'b1);
        applyStimulus("rd5b", 1'b0, 1'b1, 1'b0, 16'd5, 16'd5, 16'h0000, 2, 16'h1234, 1'b0);
        applyStimulus("rd105", 1'b0, 1'b1, 1'b0, 16'h0105, 16'h0105, 16'h0000, 2, 16'h0000, 1'b1);
`else
        applyStimulus("wr105", 1'b0, 1'b0, 1'b1, 16'h0105, 16'h0105, 16'h5555, 2, 16'h0000, 1'b0);
        applyStimulus("rd5b", 1'b0, 1'b1, 1'b0, 16'd5, 16'd5, 16'h0000, 2, 16'h5555, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder that terminates the CPU pipeline's MEM-stage request interface (the `mem_read` / `mem_write` side of the control path). It accepts one read or write request at a time and holds it for a programmable latency. It then completes the access against an internal single-port word array and returns a one-cycle acknowledge with read data. It sits between the EX/MEM pipeline register and the data storage, and gives the pipeline a realistic multi-cycle memory to stall against.

## Interface
- `WORD_W`, 16: data word width (TSC word).
- `ADDR_W`, 16: request address width.
- `DEPTH`, 256: words of storage; power of two, ≤ 2^ADDR_W.
- `LATENCY`, 2: cycles from acceptance to acknowledge; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-high reset (asserted = 1, sampled on `clk` rising edge).
- `mem_read`  in  1  read request; held until `mem_ack`.
- `mem_write`  in  1  write request; held until `mem_ack`.
- `mem_addr`  in  ADDR_W  word address; stable while request held.
- `mem_wdata`  in  WORD_W  write data; stable while request held.
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  WORD_W  read data; valid only while `mem_ack`=1 for a read.
- `busy`  out  1  request accepted and not yet acknowledged.
- `mem_err`  out  1  out-of-range access flag. Present only with `MEM_RESP_RANGE_CHK_EN`.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: if `mem_read|mem_write`, latch the op, address and wdata, load the counter with LATENCY-1, and go to WAIT (LATENCY=1: go directly to ACK). Otherwise stay in IDLE.
- Both `mem_read` and `mem_write` high: treat the request as a write. A read is not performed.
- WAIT: decrement the counter each cycle. When it reaches 0, go to ACK. Inputs are ignored while in WAIT; the request is taken from the latched copy.
- ACK: `mem_ack`=1 for exactly one cycle, then return to IDLE.
  - Read: `mem_rdata` = array[latched addr].
  - Write: the array is updated on the edge that enters ACK.
- After ACK the responder is in IDLE. A request still held high the next cycle is accepted as a new request. The CPU must drop the request in the ACK cycle if it does not want a repeat.
- Indexing: array index = latched `addr[$clog2(DEPTH)-1:0]`. Without range checking, out-of-range addresses wrap modulo DEPTH.
- `busy` = (state != IDLE).

## Timing
- Reset values: state=IDLE, `mem_ack`=0, `mem_rdata`=0, `busy`=0, `mem_err`=0, counter=0. Array contents are not reset.
- Acceptance edge = T. `mem_ack` is high during cycle T+LATENCY; `busy` is high in cycles T+1 .. T+LATENCY.
- Back-to-back throughput: one access per LATENCY+1 cycles.
- `mem_rdata` returns to 0 when `mem_ack`=0.
- Reset asserted in WAIT: abandon the request with no array write and no ack; IDLE on the next cycle.
- Reset asserted in the ACK cycle: the write has already committed; `mem_ack` drops on the next edge.

## Configuration
- `MEM_RESP_RANGE_CHK_EN` defined: `mem_err` port exists. If latched `mem_addr` ≥ DEPTH:
  - A write is suppressed.
  - A read returns 0.
  - `mem_err`=1 coincident with `mem_ack`; `mem_ack` still pulses.
- `MEM_RESP_RANGE_CHK_EN` undefined: no `mem_err` port; addresses wrap silently.

## Structure
- Shared package `tsc_mem_pkg` holds:
  - the state enum (IDLE, WAIT, ACK);
  - WORD_W/ADDR_W defaults;
  - the latency counter width constant (4 bits).
- One sub-module, `mem_array_sp`: single-port synchronous write with combinational read, parameterised on WORD_W/DEPTH. The FSM and latch registers stay in `mem_responder`.

## Test plan
- Reset, then write 0x1234 to addr 5 with LATENCY=2 → `mem_ack` at T+2, `busy` high T+1..T+2. A subsequent read of addr 5 acks at T'+2 with `mem_rdata`=0x1234.
- LATENCY=1, read and write both high, wdata 0xBEEF, addr 9 → treated as a write, ack at T+1. A read of 9 returns 0xBEEF.
- Request held high through ACK → second access accepted at ACK+1; two acks spaced LATENCY+1 cycles apart.
- Reset asserted mid-WAIT of a write of 0xAAAA to addr 3 (previously 0x0000) → no ack, `busy`=0 next cycle, a read of 3 returns 0x0000.
- `mem_addr` changed during WAIT → the access uses the originally latched address.
- With `MEM_RESP_RANGE_CHK_EN`, DEPTH=256:
  - Write 0x5555 to addr 0x0105 → `mem_ack`=1 and `mem_err`=1; a read of addr 5 is unchanged.
  - Without the macro, the same write lands at addr 5.
